// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared width helpers and reset values for the memory bank
package memory_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int addr_width(input int depth);
        return clog2(depth);
    endfunction

    // Counter must represent DEPTH itself, hence depth+1 states.
    function automatic int cnt_width(input int depth);
        return clog2(depth + 1);
    endfunction

    localparam logic Q_RST_BIT = 1'b0;
    localparam logic QV_RST    = 1'b0;
    localparam int   CNT_RST   = 0;

endpackage

// File: rtl/memory_bank_if.sv
// rtl/memory_bank_if.sv - write/read/clear bus of the memory bank
interface memory_bank_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    import memory_pkg::*;

    localparam int AW = addr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic             WE;
    logic [AW-1:0]    WA;
    logic [WIDTH-1:0] D;
    logic             RE;
    logic [AW-1:0]    RA;
    logic             CLR;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] _Q;
    logic             QV;
    logic [CW-1:0]    CNT;

    modport master (output WE, WA, D, RE, RA, CLR, input Q, _Q, QV, CNT);
    modport slave  (input WE, WA, D, RE, RA, CLR, output Q, _Q, QV, CNT);

endinterface

// File: rtl/memory_word.sv
// rtl/memory_word.sv - one data word with its valid bit
module memory_word #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    // Data is never reset; a cleared word is masked by its valid bit.
    always_ff @(posedge clk) begin
        if (we) data <= d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (we) begin
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/memory_bank.sv
// rtl/memory_bank.sv - DEPTH x WIDTH register bank, registered read, occupancy count; MEMORY_BANK_WRITE_FIRST_EN enables write-through read
module memory_bank
    import memory_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic           C,
    input  logic           _R,
    memory_bank_if.slave   bus
);

    localparam int AW = addr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [DEPTH-1:0] word_we;
    logic [DEPTH-1:0] rd_hit;
    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] word_data [DEPTH];

    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             wr_new;
    logic             bypass;

    logic [WIDTH-1:0] q_r;
    logic             qv_r;
    logic [CW-1:0]    cnt_r;

    // Out-of-range addresses match no word, so they neither write nor read.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        localparam logic [AW-1:0] IDX = AW'(i);

        assign word_we[i] = bus.WE && !bus.CLR && (bus.WA == IDX);
        assign rd_hit[i]  = (bus.RA == IDX);

        memory_word #(.WIDTH(WIDTH)) u_word (
            .clk   (C),
            .rst_n (_R),
            .we    (word_we[i]),
            .clr   (bus.CLR),
            .d     (bus.D),
            .data  (word_data[i]),
            .valid (valid[i])
        );
    end

    always_comb begin
        rd_data  = '0;
        rd_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (rd_hit[k] && valid[k]) begin
                rd_data  = rd_data | word_data[k];
                rd_valid = 1'b1;
            end
        end
    end

    assign wr_new = |(word_we & ~valid);

`ifdef MEMORY_BANK_WRITE_FIRST_EN
    // word_we already excludes CLR, so clear suppresses the bypass.
    assign bypass = |(word_we & rd_hit);
`else
    assign bypass = 1'b0;
`endif

    always_ff @(posedge C or negedge _R) begin
        if (!_R) begin
            q_r   <= {WIDTH{Q_RST_BIT}};
            qv_r  <= QV_RST;
            cnt_r <= CW'(CNT_RST);
        end else begin
            if (bus.RE) begin
                if (bypass) begin
                    q_r  <= bus.D;
                    qv_r <= 1'b1;
                end else begin
                    q_r  <= rd_data;
                    qv_r <= rd_valid;
                end
            end
            if (bus.CLR) begin
                cnt_r <= '0;
            end else if (wr_new) begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign bus.Q   = q_r;
    assign bus._Q  = ~q_r;
    assign bus.QV  = qv_r;
    assign bus.CNT = cnt_r;

endmodule

// File: tb/tb_memory_bank.sv
// tb/tb_memory_bank.sv - directed vector bench for memory_bank (DEPTH=8 and DEPTH=6)
module tb_memory_bank;

    logic C;
    logic _R;

    memory_bank_if #(.WIDTH(8), .DEPTH(8)) b8 ();
    memory_bank_if #(.WIDTH(8), .DEPTH(6)) b6 ();

    memory_bank #(.WIDTH(8), .DEPTH(8)) u8 (.C(C), ._R(_R), .bus(b8.slave));
    memory_bank #(.WIDTH(8), .DEPTH(6)) u6 (.C(C), ._R(_R), .bus(b6.slave));

    initial C = 1'b0;
    always #5 C = ~C;

`ifdef MEMORY_BANK_WRITE_FIRST_EN
    localparam int BYP_Q = 'h3C;
`else
    localparam int BYP_Q = 'h77;
`endif

    typedef struct {
        bit    big;
        bit    we;
        int    wa;
        int    d;
        bit    re;
        int    ra;
        bit    clr;
        int    eq;
        bit    eqv;
        int    ecnt;
        string name;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_fail;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input bit big, input bit we, input int wa, input int d,
                                input bit re, input int ra, input bit clr,
                                input int eq, input bit eqv, input int ecnt, input string name);
        vec_t v;
        v.big = big; v.we = we; v.wa = wa; v.d = d; v.re = re; v.ra = ra; v.clr = clr;
        v.eq = eq; v.eqv = eqv; v.ecnt = ecnt; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic idle();
        b8.WE = 1'b0; b8.WA = '0; b8.D = '0; b8.RE = 1'b0; b8.RA = '0; b8.CLR = 1'b0;
        b6.WE = 1'b0; b6.WA = '0; b6.D = '0; b6.RE = 1'b0; b6.RA = '0; b6.CLR = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        @(negedge C);
        idle();
        if (v.big) begin
            b8.WE = v.we; b8.WA = 3'(v.wa); b8.D = 8'(v.d);
            b8.RE = v.re; b8.RA = 3'(v.ra); b8.CLR = v.clr;
        end else begin
            b6.WE = v.we; b6.WA = 3'(v.wa); b6.D = 8'(v.d);
            b6.RE = v.re; b6.RA = 3'(v.ra); b6.CLR = v.clr;
        end
        @(posedge C);
        #1;
        if (v.big) begin
            check({v.name, " Q"},   int'(b8.Q),   v.eq);
            check({v.name, " _Q"},  int'(b8._Q),  (~v.eq) & 'hFF);
            check({v.name, " QV"},  int'(b8.QV),  int'(v.eqv));
            check({v.name, " CNT"}, int'(b8.CNT), v.ecnt);
        end else begin
            check({v.name, " Q"},   int'(b6.Q),   v.eq);
            check({v.name, " _Q"},  int'(b6._Q),  (~v.eq) & 'hFF);
            check({v.name, " QV"},  int'(b6.QV),  int'(v.eqv));
            check({v.name, " CNT"}, int'(b6.CNT), v.ecnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        n_cmp  = 0;
        n_fail = 0;

        //   big we wa d     re ra clr  eq     eqv ecnt name
        add(1, 1, 3, 'hA5, 0, 0, 0,  'h00,  0,  1, "w3_a5");
        add(1, 0, 0, 0,    1, 3, 0,  'hA5,  1,  1, "r3");
        add(1, 1, 2, 'h11, 0, 0, 0,  'hA5,  1,  2, "w2_11");
        add(1, 1, 2, 'h22, 0, 0, 0,  'hA5,  1,  2, "w2_22_rewrite");
        add(1, 0, 0, 0,    1, 2, 0,  'h22,  1,  2, "r2");
        add(1, 0, 0, 0,    1, 5, 0,  'h00,  0,  2, "r5_unwritten");
        add(1, 1, 4, 'h77, 0, 0, 0,  'h00,  0,  3, "w4_77");
        add(1, 1, 4, 'h3C, 1, 4, 0,  BYP_Q, 1,  3, "rw4_same");
        add(1, 0, 0, 0,    1, 4, 0,  'h3C,  1,  3, "r4_after");
        add(1, 1, 0, 'h01, 1, 3, 0,  'hA5,  1,  4, "w0_r3_diff");
        add(1, 1, 1, 'h02, 0, 0, 0,  'hA5,  1,  5, "w1");
        add(1, 1, 5, 'h05, 0, 0, 0,  'hA5,  1,  6, "w5");
        add(1, 1, 6, 'h06, 0, 0, 0,  'hA5,  1,  7, "w6");
        add(1, 1, 7, 'h07, 0, 0, 0,  'hA5,  1,  8, "w7_full");
        add(1, 1, 0, 'hFF, 1, 7, 1,  'h07,  1,  0, "clr_w0_r7");
        add(1, 0, 0, 0,    1, 0, 0,  'h00,  0,  0, "r0_after_clr");
        add(1, 0, 0, 0,    1, 7, 0,  'h00,  0,  0, "r7_after_clr");
        add(1, 1, 3, 'h99, 0, 0, 0,  'h00,  0,  1, "w3_99");
        add(1, 1, 3, 'hAA, 1, 3, 1,  'h99,  1,  0, "clr_rw3_nobypass");
        add(1, 0, 0, 0,    1, 3, 0,  'h00,  0,  0, "r3_after_clr");
        add(0, 1, 2, 'h10, 0, 0, 0,  'h00,  0,  1, "d6_w2");
        add(0, 0, 0, 0,    1, 2, 0,  'h10,  1,  1, "d6_r2");
        add(0, 1, 7, 'hEE, 1, 7, 0,  'h00,  0,  1, "d6_oor7");
        add(0, 1, 6, 'hEE, 1, 6, 0,  'h00,  0,  1, "d6_oor6");
        add(0, 0, 0, 0,    1, 2, 0,  'h10,  1,  1, "d6_r2_again");
        add(0, 1, 3, 'h20, 1, 5, 0,  'h00,  0,  2, "d6_w3_r5");
        add(1, 1, 0, 'h5A, 0, 0, 0,  'h00,  0,  1, "pre_w0");
        add(1, 1, 1, 'h11, 0, 0, 0,  'h00,  0,  2, "pre_w1");
        add(1, 1, 2, 'h22, 0, 0, 0,  'h00,  0,  3, "pre_w2");
        add(1, 0, 0, 0,    1, 0, 0,  'h5A,  1,  3, "pre_r0");

        _R = 1'b0;
        idle();
        repeat (2) @(negedge C);
        check("rst Q",   int'(b8.Q),   'h00);
        check("rst _Q",  int'(b8._Q),  'hFF);
        check("rst QV",  int'(b8.QV),  0);
        check("rst CNT", int'(b8.CNT), 0);
        _R = 1'b1;

        foreach (vecs[i]) begin
            v = vecs[i];
            apply(v);
        end

        // Asynchronous reset between edges must clear outputs without a clock.
        #2;
        _R = 1'b0;
        #1;
        check("async Q",     int'(b8.Q),   'h00);
        check("async _Q",    int'(b8._Q),  'hFF);
        check("async QV",    int'(b8.QV),  0);
        check("async CNT",   int'(b8.CNT), 0);
        check("async d6CNT", int'(b6.CNT), 0);
        @(negedge C);
        _R = 1'b1;

        add(1, 0, 0, 0, 1, 0, 0, 'h00, 0, 0, "post_rst_r0");
        v = vecs[vecs.size() - 1];
        apply(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
